// File: rtl/rca64_result_buf_if.sv
// Result-path bundle between the 64-bit adder, the capture buffer and its consumer.
// master = adder/consumer side, slave = the buffer.
interface rca64_result_buf_if;
   logic        in_valid;
   logic [63:0] in_sum;
   logic        in_crout;
   logic        out_ready;
   logic        out_valid;
   logic [63:0] out_sum;
   logic        out_crout;
   logic        out_zero;

   modport master (
      output in_valid, in_sum, in_crout, out_ready,
      input  out_valid, out_sum, out_crout, out_zero
   );

   modport slave (
      input  in_valid, in_sum, in_crout, out_ready,
      output out_valid, out_sum, out_crout, out_zero
   );
endinterface

// File: rtl/rca64_result_buf.sv
// Show-ahead FIFO capturing {crout, sum, zero} adder results.
// Overflowing inputs are dropped and counted, so the adder never stalls.
module rca64_result_buf #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   rca64_result_buf_if.slave         bus,
   input  logic                      err_clr,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full,
   output logic                      empty,
   output logic [CNT_W-1:0]          drop_cnt,
   output logic                      overflow_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   localparam logic [AW-1:0]    PTR_ZERO  = AW'(0);
   localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
   localparam logic [OW-1:0]    OCC_ZERO  = OW'(0);
   localparam logic [OW-1:0]    OCC_ONE   = OW'(1);
   localparam logic [OW-1:0]    OCC_FULL  = OW'(DEPTH);
   localparam logic [CNT_W-1:0] DROP_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] DROP_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] DROP_MAX  = {CNT_W{1'b1}};

   function automatic logic is_zero(input logic [63:0] v);
      return (v == 64'h0);
   endfunction

   logic [63:0]      sum_mem_r   [DEPTH];
   logic             crout_mem_r [DEPTH];
   logic             zero_mem_r  [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [OW-1:0]    count_r;
   logic [CNT_W-1:0] drop_cnt_r;
   logic             overflow_err_r;

   logic empty_s;
   logic full_s;
   logic pop_s;
   logic push_s;
   logic drop_s;

   assign empty_s = (count_r == OCC_ZERO);
   assign full_s  = (count_r == OCC_FULL);
   assign pop_s   = ~empty_s & bus.out_ready;
   // A full buffer still accepts a push when the head leaves in the same cycle.
   assign push_s  = bus.in_valid & (~full_s | pop_s);
   assign drop_s  = bus.in_valid & full_s & ~pop_s;

   // Entry storage; contents are don't-care after reset.
   always_ff @(posedge clock) begin
      if (push_s) begin
         sum_mem_r[wr_ptr_r]   <= bus.in_sum;
         crout_mem_r[wr_ptr_r] <= bus.in_crout;
         zero_mem_r[wr_ptr_r]  <= is_zero(bus.in_sum);
      end
   end

   // Pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= OCC_ZERO;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + OCC_ONE;
            2'b01:   count_r <= count_r - OCC_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Drop accounting; a drop in the same cycle as err_clr wins.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         drop_cnt_r     <= DROP_ZERO;
         overflow_err_r <= 1'b0;
      end else if (drop_s) begin
         overflow_err_r <= 1'b1;
         if (err_clr) begin
            drop_cnt_r <= DROP_ONE;
         end else if (drop_cnt_r != DROP_MAX) begin
            drop_cnt_r <= drop_cnt_r + DROP_ONE;
         end
      end else if (err_clr) begin
         drop_cnt_r     <= DROP_ZERO;
         overflow_err_r <= 1'b0;
      end
   end

   // Show-ahead head entry, forced to zero while empty.
   always_comb begin
      bus.out_valid = 1'b0;
      bus.out_sum   = 64'h0;
      bus.out_crout = 1'b0;
      bus.out_zero  = 1'b0;
      if (empty_s) begin
         bus.out_valid = 1'b0;
      end else begin
         bus.out_valid = 1'b1;
         bus.out_sum   = sum_mem_r[rd_ptr_r];
         bus.out_crout = crout_mem_r[rd_ptr_r];
         bus.out_zero  = zero_mem_r[rd_ptr_r];
      end
   end

   assign count        = count_r;
   assign full         = full_s;
   assign empty        = empty_s;
   assign drop_cnt     = drop_cnt_r;
   assign overflow_err = overflow_err_r;
endmodule

// File: tb/tb_rca64_result_buf.sv
// Scoreboard bench for rca64_result_buf: a reference queue predicts every
// head entry, occupancy flag and drop counter value.
module tb_rca64_result_buf;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int DMAX  = (1 << CNT_W) - 1;

   logic             clock;
   logic             reset;
   logic             err_clr;
   logic [2:0]       count;
   logic             full;
   logic             empty;
   logic [CNT_W-1:0] drop_cnt;
   logic             overflow_err;

   rca64_result_buf_if bus ();

   rca64_result_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clock        (clock),
      .reset        (reset),
      .bus          (bus.slave),
      .err_clr      (err_clr),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .drop_cnt     (drop_cnt),
      .overflow_err (overflow_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_vec;
   int n_mis;
   logic [65:0] q[$];  // {crout, zero, sum}
   int m_drop;
   logic m_oerr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ":out_valid"}, 64'(bus.out_valid), 64'(q.size() != 0));
      chk({tag, ":count"}, 64'(count), 64'(q.size()));
      chk({tag, ":full"}, 64'(full), 64'(q.size() == DEPTH));
      chk({tag, ":empty"}, 64'(empty), 64'(q.size() == 0));
      chk({tag, ":drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
      chk({tag, ":overflow_err"}, 64'(overflow_err), 64'(m_oerr));
      if (q.size() == 0) begin
         chk({tag, ":out_sum"}, bus.out_sum, 64'h0);
         chk({tag, ":out_crout"}, 64'(bus.out_crout), 64'h0);
         chk({tag, ":out_zero"}, 64'(bus.out_zero), 64'h0);
      end else begin
         chk({tag, ":out_sum"}, bus.out_sum, q[0][63:0]);
         chk({tag, ":out_crout"}, 64'(bus.out_crout), 64'(q[0][65]));
         chk({tag, ":out_zero"}, 64'(bus.out_zero), 64'(q[0][64]));
      end
   endtask

   // Apply the currently driven inputs for one clock, updating the model.
   task automatic step(input string tag);
      int occ;
      logic pop_m, push_m, drop_m;
      logic [65:0] e;
      check_state(tag);
      occ    = q.size();
      pop_m  = bus.out_ready && (occ > 0);
      push_m = bus.in_valid && ((occ < DEPTH) || pop_m);
      drop_m = bus.in_valid && !push_m;
      if (pop_m) begin
         e = q.pop_front();
         chk({tag, ":pop_sum"}, bus.out_sum, e[63:0]);
      end
      if (push_m) q.push_back({bus.in_crout, (bus.in_sum == 64'h0), bus.in_sum});
      if (drop_m) begin
         m_oerr = 1'b1;
         if (err_clr) m_drop = 1;
         else if (m_drop < DMAX) m_drop = m_drop + 1;
      end else if (err_clr) begin
         m_drop = 0;
         m_oerr = 1'b0;
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic drive(input logic v, input logic [63:0] s, input logic c, input logic r);
      bus.in_valid  = v;
      bus.in_sum    = s;
      bus.in_crout  = c;
      bus.out_ready = r;
   endtask

   initial begin
      n_vec = 0;
      n_mis = 0;
      m_drop = 0;
      m_oerr = 1'b0;
      err_clr = 1'b0;
      reset = 1'b0;
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      #4 reset = 1'b1;
      @(negedge clock);
      check_state("reset");

      // single capture, then pop
      drive(1'b1, 64'hf20f_ffff_ffff_ff4f, 1'b1, 1'b0);
      step("cap_push");
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      step("cap_hold");
      drive(1'b0, 64'h0, 1'b0, 1'b1);
      step("cap_pop");
      drive(1'b0, 64'h0, 1'b0, 1'b1);
      step("empty_ready");

      // zero flag
      drive(1'b1, 64'h0, 1'b1, 1'b0);
      step("zero_push");
      drive(1'b0, 64'h0, 1'b0, 1'b1);
      step("zero_pop");

      // fill and overflow: 5 pushes, value 5 dropped
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 64'(i), 1'b0, 1'b0);
         step("fill");
      end
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      step("full_hold");
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 64'h0, 1'b0, 1'b1);
         step("drain");
      end

      // full with simultaneous push/pop streams without loss
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, {$urandom, $urandom}, 1'($urandom), 1'b0);
         step("refill");
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, {$urandom, $urandom}, 1'($urandom), 1'b1);
         step("stream");
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 64'h0, 1'b0, 1'b1);
         step("drain2");
      end

      // mid-operation asynchronous reset with count=3
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 64'(100 + i), 1'b1, 1'b0);
         step("pre_rst");
      end
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      #2 reset = 1'b0;
      q.delete();
      m_drop = 0;
      m_oerr = 1'b0;
      #1 check_state("mid_rst");
      @(negedge clock);
      reset = 1'b1;
      check_state("post_rst");

      // two drops, then err_clr coinciding with a drop, then err_clr alone
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 64'(200 + i), 1'b0, 1'b0);
         step("drop_fill");
      end
      err_clr = 1'b1;
      drive(1'b1, 64'h1234, 1'b0, 1'b0);
      step("clr_vs_drop");
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      step("clr_alone");
      err_clr = 1'b0;
      step("clr_done");

      // drop counter saturation
      for (int i = 0; i < DMAX + 5; i++) begin
         drive(1'b1, 64'(i), 1'b0, 1'b0);
         step("saturate");
      end
      drive(1'b0, 64'h0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step("final_drain");
      check_state("end");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule

// File: doc/rca64_result_buf.md
Name: rca64_result_buf

Overview:
- Downstream capture stage for the 64-bit ripple-carry adder.
- Registers each valid {crout, sum} result into a small FIFO and presents it to the consumer with a valid/ready handshake.
- Tags each entry with a zero flag.
- Counts results that are dropped because the buffer was full, so the adder never needs back-pressure.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clock  input  1  rising-edge clock shared with the adder.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  adder sum/crout are valid this cycle (aligned to the adder's registered output).
- in_sum  input  64  adder sum.
- in_crout  input  1  adder carry-out.
- out_ready  input  1  consumer accepts the head entry this cycle.
- err_clr  input  1  synchronous clear of overflow_err and drop_cnt.
- out_valid  output  1  head entry present (equals !empty).
- out_sum  output  64  head entry sum.
- out_crout  output  1  head entry carry.
- out_zero  output  1  head entry sum == 0; computed at write time and stored with the entry.
- count  output  log2(DEPTH)+1  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- drop_cnt  output  CNT_W  number of dropped inputs; saturating.
- overflow_err  output  1  sticky; set on the first drop.

Behaviour:
- Reset (reset=0, asynchronous, any time, including mid-transfer):
  - wr_ptr, rd_ptr, count, drop_cnt and overflow_err go to 0.
  - out_valid=0, empty=1, full=0.
  - out_sum=0, out_crout=0, out_zero=0, forced while empty.
  - Storage contents are don't-care.
  - Reset release is synchronous to the next clock edge; the first push can occur on the first rising edge with reset=1.
- Organisation:
  - Circular buffer with wr_ptr/rd_ptr of log2(DEPTH) bits; both wrap DEPTH-1 -> 0.
  - count tracked separately, not derived from the pointers.
  - Show-ahead: out_* are driven combinationally from the entry at rd_ptr.
  - While empty, out_* are forced to 0.
- Definitions:
  - pop = out_valid & out_ready.
  - push = in_valid & (!full | pop).
- Push: write {in_crout, in_sum, (in_sum==64'h0)} at wr_ptr, then wr_ptr+1.
- Pop: rd_ptr+1.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop: unchanged.
  - neither: unchanged.
- Latency: a result pushed at edge k into an empty buffer appears on out_* with out_valid=1 immediately after edge k. There is no bypass of the storage register.
- Full with simultaneous pop: the push is accepted, so an in_valid every cycle with out_ready held high streams without loss.
- Drop (in_valid & full & !pop):
  - Input is discarded.
  - drop_cnt increments, saturating at 2^CNT_W-1.
  - overflow_err set to 1.
- Empty with out_ready=1: no pop, no state change.
- out_ready is ignored when out_valid=0.
- err_clr:
  - Next edge: overflow_err=0, drop_cnt=0.
  - If a drop occurs in the same cycle, the drop wins: drop_cnt=1, overflow_err=1.
- Stability: out_* must hold while out_valid=1 and out_ready=0, regardless of pushes.
- No combinational path from in_* to out_*. A combinational path from out_ready to out_* exists only through the pointer registers, i.e. the next cycle.

Test Plan:
1. Reset: hold reset=0 for 4 ns, then release; in_valid=0 -> out_valid=0, empty=1, count=0, out_sum=0, drop_cnt=0, overflow_err=0.
2. Single capture:
   - Stimulus: in_sum=64'hf20f_ffff_ffff_ff4f, in_crout=1, in_valid=1 for one cycle, out_ready=0.
   - Expected: next cycle out_valid=1, out_sum=64'hf20f_ffff_ffff_ff4f, out_crout=1, out_zero=0, count=1.
   - Then out_ready=1 for one cycle -> empty=1.
3. Zero flag: push in_sum=0 with in_crout=1 -> out_zero=1, out_crout=1.
4. Fill and overflow:
   - Push 5 results 1,2,3,4,5 with out_ready=0 -> full=1, count=4, drop_cnt=1, overflow_err=1.
   - Then drain -> out_sum sequence 1,2,3,4; the value 5 never appears.
5. Full with simultaneous push/pop: with the buffer full, hold in_valid=1 and out_ready=1 for 10 cycles -> count stays 4, drop_cnt does not change, outputs appear in push order.
6. Mid-operation reset and err_clr:
   - Assert reset=0 between clock edges with count=3 -> outputs clear immediately.
   - After release, err_clr=1 in the same cycle as a drop -> drop_cnt=1, overflow_err=1.
